// File: rtl/scroll_commander.sv
// scroll_commander: plans and emits spaced step pulses that walk a saturating scroller to a target
module scroll_commander #(
   parameter int POS_W = 2,
   parameter int GAP   = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [POS_W-1:0] target,
   output logic             step_right,
   output logic             step_left,
   output logic [POS_W-1:0] pos,
   output logic             busy,
   output logic             done
);
   typedef enum logic [1:0] {S_IDLE, S_STEP, S_GAP, S_DONE} state_t;
   localparam logic [7:0] GAP_LD = 8'(GAP - 1);
   state_t           state, state_d;
   logic [POS_W-1:0] tgt_q, tgt_d, pos_d;
   logic [7:0]       cnt, cnt_d;
   logic             step_right_d, step_left_d, busy_d, done_d;
   // next state and next registered outputs; the pulse for a step is set up one edge early so it is a clean register output
   always_comb begin
      state_d      = state;
      tgt_d        = tgt_q;
      pos_d        = pos;
      cnt_d        = cnt;
      step_right_d = 1'b0;
      step_left_d  = 1'b0;
      busy_d       = busy;
      done_d       = 1'b0;
      case (state)
         S_IDLE: begin
            busy_d = 1'b0;
            if (start) begin
               tgt_d        = target;
               state_d      = (target != pos) ? S_STEP : S_DONE;
               step_right_d = target > pos;
               step_left_d  = target < pos;
               busy_d       = target != pos;
               done_d       = target == pos;
            end
         end
         S_STEP: begin
            pos_d   = step_right ? pos + 1'b1 : pos - 1'b1;
            state_d = (pos_d == tgt_q) ? S_DONE : S_GAP;
            done_d  = pos_d == tgt_q;
            busy_d  = pos_d != tgt_q;
            cnt_d   = GAP_LD;
         end
         S_GAP: begin
            state_d      = (cnt == 8'd0) ? S_STEP : S_GAP;
            step_right_d = cnt == 8'd0 && tgt_q > pos;
            step_left_d  = cnt == 8'd0 && tgt_q < pos;
            cnt_d        = (cnt == 8'd0) ? cnt : cnt - 8'd1;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end
   // state and output registers; reset aborts any move without a done pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         tgt_q      <= '0;
         pos        <= '0;
         cnt        <= '0;
         step_right <= 1'b0;
         step_left  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_d;
         tgt_q      <= tgt_d;
         pos        <= pos_d;
         cnt        <= cnt_d;
         step_right <= step_right_d;
         step_left  <= step_left_d;
         busy       <= busy_d;
         done       <= done_d;
      end
   end
endmodule

// File: doc/scroll_commander.md
# scroll_commander

Command-side driver for the two-input saturating position scroller: accepts a target position and emits single-cycle `step_right` / `step_left` pulses on the scroller's `inRight` / `inLeft` inputs until the scroller reaches the target. It keeps a mirror of the scroller position so it can plan moves without reading back. It sits between control logic (menu or game FSM) and the scroller that drives the hex display selection. Both blocks reset together.

## Interface
- `POS_W`, default 2: position width. Positions are 0 .. 2^POS_W-1.
- `GAP`, default 3: idle cycles between consecutive step pulses. Legal range is 1..255.

- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high; clock clk.
- `start`  in  1  command strobe. Sampled only in IDLE.
- `target`  in  POS_W  requested position. Latched with `start`.
- `step_right`  out  1  one-cycle pulse. Connects to the scroller's inRight.
- `step_left`  out  1  one-cycle pulse. Connects to the scroller's inLeft.
- `pos`  out  POS_W  mirrored scroller position.
- `busy`  out  1  high while a move is in progress.
- `done`  out  1  one-cycle pulse when the move completes.

## Operation
- All outputs are registered.
- Reset values: `step_right`=0, `step_left`=0, `pos`=0, `busy`=0, `done`=0, state=IDLE, gap counter=0.
- A reset in any state, including mid-move, aborts immediately and gives these values on the next cycle. No `done` pulse is issued for an aborted move.
- States: IDLE, STEP, GAP, DONE.
- IDLE:
  - `start`=1 latches `target` into `tgt_q`.
  - If `tgt_q` != `pos`, go to STEP.
  - If `tgt_q` == `pos`, go to DONE. No pulses are issued.
- STEP (one cycle): drive exactly one of the step outputs.
  - `step_right`=1 if `tgt_q` > `pos` (unsigned compare).
  - Otherwise `step_left`=1.
  - At the end of the cycle, `pos` increments or decrements by 1.
  - If the new `pos` == `tgt_q`, go to DONE. Otherwise go to GAP and load the counter with GAP-1.
- GAP: both step outputs are 0. The counter decrements each cycle; at 0, go to STEP.
- DONE (one cycle): `done`=1, `busy`=0, then go to IDLE.
- `step_right` and `step_left` are never high in the same cycle. The scroller treats both-high as hold, so this rule prevents a desync.
- `pos` never leaves 0 .. 2^POS_W-1. Moves are always toward an in-range target, so the scroller's saturation is never exercised and the mirror stays exact.
- `start` is ignored in STEP, GAP and DONE. It is neither queued nor does it retarget the move.
- `target` changes after the latch cycle have no effect.

## Timing
- `start` is sampled at edge k in IDLE.
  - Move case: first pulse is high in cycle k+1, and `busy` goes high in cycle k+1.
  - Null move: `done` is high in cycle k+1.
- Pulse n (n = 0..d-1, where d = |target - pos|) is high in cycle k+1+n*(GAP+1).
- `pos` reflects step n from cycle k+2+n*(GAP+1). This matches the scroller's `ps` update on the same edge.
- `done` is high in cycle k+2+(d-1)*(GAP+1), the cycle right after the last pulse. There is no trailing gap.
- `busy` is high from cycle k+1 through the last pulse cycle, and low in the DONE cycle.
- The next `start` is accepted at the edge ending the DONE cycle + 1, i.e. the first IDLE cycle.
- Minimum spacing between pulses is GAP idle cycles.

## Test plan
All scenarios use POS_W=2, GAP=3.
- Reset then idle for 3 cycles → all outputs 0, `pos`=0.
- `start`, `target`=3 from `pos`=0 → `step_right` in cycles k+1, k+5, k+9; `pos` = 1, 2, 3 after each pulse; `done` at k+10; `step_left` stays 0 throughout.
- `start`, `target`=1 from `pos`=3 → `step_left` at k+1 and k+5; `done` at k+6; final `pos`=1.
- `start`, `target`=`pos`=1 → no pulses, `busy` stays 0, `done` at k+1.
- `start` pulsed with `target`=0 during the GAP of a 1→3 move → ignored: the move completes to 3 and only one `done` is issued.
- Reset asserted in the GAP after the first pulse of a 0→3 move → next cycle all outputs 0, `pos`=0, no `done`. Then run a co-simulation with the scroller: its `out` equals `pos` every cycle across the full sequence.
